riscv_lsu: RTL
==============

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for dmem_ack.
REQ-004 SHALL have ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream instruction valid.
- op_in  input  2  operation: 0 NONE, 1 LOAD, 2 LOAD_U, 3 STORE.
- size_in  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
- addr_in  input  ADDR_W  byte address.
- wdata_in  input  XLEN  store data, LSB-aligned.
- rd_write_in / rd_addr_in / rd_data_in  input  1 / 5 / XLEN  writeback passthrough.
- stall_in  input  1  downstream stall.
- busy  output  1  upstream must hold inputs.
- dmem_req  output  1  bus request.
- dmem_we  output  1  write.
- dmem_addr  output  ADDR_W  address aligned to XLEN/8 bytes.
- dmem_be  output  XLEN/8  byte enables.
- dmem_wdata  output  XLEN  lane-shifted store data.
- dmem_ack  input  1  access complete.
- dmem_rdata  input  XLEN  read data.
- dmem_err  input  1  bus error, valid with dmem_ack.
- valid_out / rd_write_out / rd_addr_out / rd_data_out  output  1 / 1 / 5 / XLEN  result.
- exc_out  output  1  exception.
- exc_cause_out  output  4  mcause code.
- exc_tval_out  output  ADDR_W  faulting address.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS and HOLD.
REQ-006 In IDLE, SHALL accept an instruction when valid_in=1 and busy=0; accepting a memory op with stall_in=0 SHALL be a single cycle.
REQ-007 On accepting op NONE with stall_in=0, SHALL register passthrough outputs with valid_out=1 on the next edge (latency 1).
REQ-008 On accepting an aligned memory op, SHALL enter ACCESS and assert dmem_req from the next cycle until the dmem_ack cycle inclusive.
REQ-009 While in ACCESS, dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be stable.
REQ-010 Byte lane SHALL be addr[log2(XLEN/8)-1:0]; dmem_be SHALL be (1,3,F,FF)[size] shifted left by the lane; dmem_wdata SHALL be wdata_in shifted left by 8*lane.
REQ-011 Loads SHALL shift dmem_rdata right by 8*lane, then sign-extend (LOAD) or zero-extend (LOAD_U) from the access size to XLEN.
REQ-012 A word load at XLEN=64 SHALL extend according to op.
REQ-013 On dmem_ack=1 with dmem_err=0, SHALL register the result with valid_out=1 on the next edge.
REQ-014 rd_write_out SHALL be rd_write_in for loads and 0 for stores.
REQ-015 Misalignment (half with addr[0]=1, word with addr[1:0]!=0, double with addr[2:0]!=0) SHALL issue no bus request.
REQ-016 A misaligned access SHALL produce valid_out=1 and exc_out=1 next cycle, with cause 4 (load) or 6 (store) and tval=addr_in.
REQ-017 size 3 with XLEN=32 SHALL be treated as an access fault without a bus request.
REQ-018 dmem_err=1 with dmem_ack, or TIMEOUT cycles in ACCESS without ack, SHALL produce exc_out=1 with cause 5 (load) or 7 (store).
REQ-019 On a timeout, dmem_req SHALL be deasserted.
REQ-020 Any exception SHALL force rd_write_out=0.
REQ-021 If stall_in=1 when a result is ready, SHALL enter HOLD and keep all outputs stable until stall_in=0.
REQ-022 The timeout counter SHALL clear on entry to ACCESS and SHALL saturate.
REQ-023 busy SHALL be 1 in ACCESS or HOLD, and in IDLE whenever stall_in=1.
REQ-024 dmem_ack outside ACCESS SHALL be ignored.
REQ-025 When leaving HOLD, a new instruction SHALL NOT be accepted in the same cycle.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE and clear the timeout counter.
REQ-027 reset_n low SHALL force dmem_req=0, dmem_we=0, dmem_be=0, valid_out=0, rd_write_out=0, exc_out=0, exc_cause_out=0 and exc_tval_out=0.
REQ-028 Reset during ACCESS SHALL drop dmem_req immediately and discard the transaction.

Verification
REQ-029 LOAD byte at addr 0x103, dmem_rdata=0x80FF_FFFF, XLEN=32 -> dmem_be=0x8, rd_data_out=0xFFFF_FF80.
REQ-030 LOAD_U half at 0x102, dmem_rdata=0x8001_0000 -> dmem_be=0xC, rd_data_out=0x0000_8001.
REQ-031 STORE byte 0xAB at 0x201 -> dmem_we=1, dmem_be=0x2, dmem_wdata[15:8]=0xAB, rd_write_out=0.
REQ-032 LOAD word at 0x102 -> dmem_req never asserted, exc_out=1, cause 4, tval 0x102.
REQ-033 STORE word, dmem_ack withheld with TIMEOUT=4 -> dmem_req falls after 4 cycles, exc_out=1, cause 7.
REQ-034 Load ack while stall_in=1 for 3 cycles -> outputs held stable in HOLD, busy=1, then released.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit.
// Accepts one instruction at a time, performs a single aligned data-memory
// access, and returns the lane-aligned and extended load data or an exception.
// Op NONE passes the writeback fields straight through with one cycle of latency.
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [1:0]        op_in,
    input  logic [1:0]        size_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic              rd_write_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [XLEN-1:0]   rd_data_in,
    input  logic              stall_in,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_err,
    output logic              valid_out,
    output logic              rd_write_out,
    output logic [4:0]        rd_addr_out,
    output logic [XLEN-1:0]   rd_data_out,
    output logic              exc_out,
    output logic [3:0]        exc_cause_out,
    output logic [ADDR_W-1:0] exc_tval_out
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_NONE   = 2'd0;
    localparam logic [1:0] OP_LOAD   = 2'd1;
    localparam logic [1:0] OP_STORE  = 2'd3;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Request-side context captured at acceptance
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [1:0]        r_size;
    logic [LANE_W-1:0] r_lane;
    logic [ADDR_W-1:0] r_tval;
    logic              r_rd_write;
    logic [4:0]        r_rd_addr;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [BE_W-1:0]   r_dmem_be;
    logic [XLEN-1:0]   r_dmem_wdata;

    // Result registers
    logic              r_valid_out;
    logic              r_rd_write_out;
    logic [4:0]        r_rd_addr_out;
    logic [XLEN-1:0]   r_rd_data_out;
    logic              r_exc;
    logic [3:0]        r_exc_cause;
    logic [ADDR_W-1:0] r_exc_tval;

    // Decode / datapath wires
    logic [LANE_W-1:0] w_lane_in;
    logic              w_is_mem;
    logic              w_is_store_in;
    logic              w_misaligned;
    logic              w_size_fault;
    logic [7:0]        w_be_base;
    logic [7:0]        w_be_shift;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_mask;
    logic [XLEN-1:0]   w_load_data;
    logic              w_sign_bit;
    int                w_bits;

    // FSM output wires
    logic w_busy;
    logic w_accept;
    logic w_issue;
    logic w_imm_result;
    logic w_timeout;
    logic w_done;

    assign w_lane_in     = addr_in[LANE_W-1:0];
    assign w_is_mem      = (op_in != OP_NONE);
    assign w_is_store_in = (op_in == OP_STORE);

    // Request decode: alignment check, size fault and byte-enable pattern
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_misaligned = 1'b0;
        w_be_base    = 8'h00;
        case (size_in)
            2'd0: begin w_misaligned = 1'b0;           w_be_base = 8'h01; end
            2'd1: begin w_misaligned = addr_in[0];     w_be_base = 8'h03; end
            2'd2: begin w_misaligned = |addr_in[1:0];  w_be_base = 8'h0F; end
            default: begin w_misaligned = |addr_in[2:0]; w_be_base = 8'hFF; end
        endcase
        w_size_fault = (XLEN == 32) && (size_in == 2'd3);
        w_be_shift   = w_be_base << w_lane_in;
    end

    // Load path: move the addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        w_shifted  = dmem_rdata >> {r_lane, 3'b000};
        w_bits     = XLEN;
        w_sign_bit = 1'b0;
        case (r_size)
            2'd0:    begin w_bits = 8;    w_sign_bit = w_shifted[7];      end
            2'd1:    begin w_bits = 16;   w_sign_bit = w_shifted[15];     end
            2'd2:    begin w_bits = 32;   w_sign_bit = w_shifted[31];     end
            default: begin w_bits = XLEN; w_sign_bit = w_shifted[XLEN-1]; end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            w_mask[i] = (i < w_bits);
        end
        w_load_data = (w_shifted & w_mask)
                    | ({XLEN{w_sign_bit && (r_op == OP_LOAD)}} & ~w_mask);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_issue) w_next_state = S_ACCESS;
            S_ACCESS: if (w_done)  w_next_state = stall_in ? S_HOLD : S_IDLE;
            S_HOLD:   if (!stall_in) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: handshake, bus request and completion strobes
    always_comb begin
        // Busy while a transaction is outstanding or held, and whenever downstream stalls;
        // this also keeps the HOLD exit cycle from accepting a new instruction.
        w_busy       = (r_state != S_IDLE) || stall_in;
        w_accept     = (r_state == S_IDLE) && valid_in && !w_busy;
        w_issue      = w_accept && w_is_mem && !w_misaligned && !w_size_fault;
        w_imm_result = w_accept && !w_issue;
        w_timeout    = (r_state == S_ACCESS) && (r_cnt >= CNT_W'(TIMEOUT - 1));
        w_done       = (r_state == S_ACCESS) && (dmem_ack || w_timeout);
    end

    // Wait counter: cleared when a request is issued, saturates at TIMEOUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if ((r_state == S_ACCESS) && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bus-side registers: loaded once at issue so they stay stable through ACCESS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op         <= OP_NONE;
            r_size       <= 2'd0;
            r_lane       <= '0;
            r_tval       <= '0;
            r_rd_write   <= 1'b0;
            r_rd_addr    <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
        end else if (w_issue) begin
            r_op         <= op_in;
            r_size       <= size_in;
            r_lane       <= w_lane_in;
            r_tval       <= addr_in;
            r_rd_write   <= rd_write_in;
            r_rd_addr    <= rd_addr_in;
            r_dmem_we    <= w_is_store_in;
            r_dmem_addr  <= {addr_in[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            r_dmem_be    <= w_be_shift[BE_W-1:0];
            r_dmem_wdata <= wdata_in << {w_lane_in, 3'b000};
        end
    end

    // Result registers: immediate results, bus completions, hold under stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_out    <= 1'b0;
            r_rd_write_out <= 1'b0;
            r_rd_addr_out  <= '0;
            r_rd_data_out  <= '0;
            r_exc          <= 1'b0;
            r_exc_cause    <= '0;
            r_exc_tval     <= '0;
        end else if (w_imm_result) begin
            r_valid_out   <= 1'b1;
            r_rd_addr_out <= rd_addr_in;
            if (!w_is_mem) begin
                r_rd_write_out <= rd_write_in;
                r_rd_data_out  <= rd_data_in;
                r_exc          <= 1'b0;
                r_exc_cause    <= '0;
                r_exc_tval     <= '0;
            end else begin
                // Unsupported size is an access fault; otherwise misaligned
                r_rd_write_out <= 1'b0;
                r_rd_data_out  <= '0;
                r_exc          <= 1'b1;
                r_exc_tval     <= addr_in;
                if (w_size_fault) r_exc_cause <= w_is_store_in ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                else              r_exc_cause <= w_is_store_in ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            end
        end else if (w_done) begin
            r_valid_out   <= 1'b1;
            r_rd_addr_out <= r_rd_addr;
            if (dmem_ack && !dmem_err) begin
                r_rd_write_out <= (r_op == OP_STORE) ? 1'b0 : r_rd_write;
                r_rd_data_out  <= (r_op == OP_STORE) ? '0 : w_load_data;
                r_exc          <= 1'b0;
                r_exc_cause    <= '0;
                r_exc_tval     <= '0;
            end else begin
                // Bus error or timeout
                r_rd_write_out <= 1'b0;
                r_rd_data_out  <= '0;
                r_exc          <= 1'b1;
                r_exc_cause    <= (r_op == OP_STORE) ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                r_exc_tval     <= r_tval;
            end
        end else if ((r_state == S_HOLD) && stall_in) begin
            r_valid_out <= r_valid_out;
        end else begin
            r_valid_out    <= 1'b0;
            r_rd_write_out <= 1'b0;
            r_exc          <= 1'b0;
        end
    end

    assign busy          = w_busy;
    assign dmem_req      = (r_state == S_ACCESS);
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_be       = r_dmem_be;
    assign dmem_wdata    = r_dmem_wdata;
    assign valid_out     = r_valid_out;
    assign rd_write_out  = r_rd_write_out;
    assign rd_addr_out   = r_rd_addr_out;
    assign rd_data_out   = r_rd_data_out;
    assign exc_out       = r_exc;
    assign exc_cause_out = r_exc_cause;
    assign exc_tval_out  = r_exc_tval;

endmodule
